// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready pipeline stage with a 2-entry skid buffer and sync flush
// Ports: clk, rst (async, active-high), flush (sync kill of held entries);
//   upstream in_valid/in_ready/in_data/in_ctrl; downstream out_valid/out_ready/out_data/out_ctrl;
//   occupancy = held entries 0..2; stall_cnt/bubble_cnt saturating perf counters,
//   present only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
`ifdef PIPE_STAGE_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic acc, take, main_in, main_skid, skid_in;
  // in_ready depends on state only, so upstream never sees a path from out_ready
  assign in_ready = state != FULL;
  assign out_valid = state != EMPTY;
  assign acc = in_valid & in_ready;
  assign take = out_valid & out_ready;
  assign occupancy = state;
  assign out_data = main_data;
  // gated so an idle stage always looks like a bubble (regwrite=0) downstream
  assign out_ctrl = out_valid ? main_ctrl : '0;
  always_comb begin
    state_nx = state;
    main_in = 1'b0;
    main_skid = 1'b0;
    skid_in = 1'b0;
    if (flush) state_nx = EMPTY;
    else unique case (state)
      EMPTY: begin
        main_in = acc;
        state_nx = acc ? ONE : EMPTY;
      end
      ONE: begin
        main_in = acc & take;
        skid_in = acc & !take;
        state_nx = acc ? (take ? ONE : FULL) : (take ? EMPTY : ONE);
      end
      FULL: begin
        main_skid = take;
        state_nx = take ? ONE : FULL;
      end
      default: state_nx = EMPTY;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= state_nx;
      if (flush) begin
        main_ctrl <= '0;
        skid_ctrl <= '0;
      end else begin
        if (main_in) {main_ctrl, main_data} <= {in_ctrl, in_data};
        else if (main_skid) {main_ctrl, main_data} <= {skid_ctrl, skid_data};
        if (skid_in) {skid_ctrl, skid_data} <= {in_ctrl, in_data};
      end
    end
  end
`ifdef PIPE_STAGE_PERF_EN
  // saturating counters; flush does not clear them and its own cycle is counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (!out_valid && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed vector table, async reset, and random scoreboard checks for pipe_stage_buf
module tb_pipe_stage_buf;
  localparam int DW = 64;
  localparam int CW = 8;
  typedef struct {
    logic fl, iv;
    logic [7:0] d;
    logic ordy, ov;
    logic [7:0] od, oc;
    logic [1:0] occ;
    logic ir;
  } vec_t;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0] occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [3:0] stall_cnt, bubble_cnt;
`endif
  int n = 0, errs = 0;
  vec_t tbl[17];
  logic [71:0] q[$];
  always #5 clk = ~clk;
  pipe_stage_buf #(
    .DATA_W(DW),
    .CTRL_W(CW)
`ifdef PIPE_STAGE_PERF_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );
  function automatic vec_t v(logic fl, logic iv, logic [7:0] d, logic ordy, logic ov,
                             logic [7:0] od, logic [7:0] oc, logic [1:0] occ, logic ir);
    v = '{fl, iv, d, ordy, ov, od, oc, occ, ir};
  endfunction
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask
  task automatic expect_st(input string nm, input logic ov, input logic chkd, input logic [DW-1:0] d,
                           input logic [CW-1:0] c, input logic [1:0] occ, input logic ir);
    n++;
    if (out_valid !== ov || (chkd && out_data !== d) || out_ctrl !== c || occupancy !== occ || in_ready !== ir) begin
      errs++;
      $display("FAIL %s: got ov=%b data=%h ctrl=%h occ=%0d ir=%b, want ov=%b data=%h ctrl=%h occ=%0d ir=%b",
               nm, out_valid, out_data, out_ctrl, occupancy, in_ready, ov, d, c, occ, ir);
    end
  endtask
  task automatic cyc(input logic fl, input logic iv, input logic [7:0] d, input logic ordy);
    flush = fl;
    in_valid = iv;
    in_data = DW'(d);
    in_ctrl = {1'b1, d[6:0]};
    out_ready = ordy;
    @(negedge clk);
  endtask
  initial begin
    logic acc, take, hold;
    logic [71:0] held, head;
    //        fl iv d      ordy ov od     oc     occ ir
    tbl[0]  = v(0, 1, 8'h01, 1, 1, 8'h01, 8'h81, 1, 1);
    tbl[1]  = v(0, 1, 8'h02, 1, 1, 8'h02, 8'h82, 1, 1);
    tbl[2]  = v(0, 1, 8'h03, 1, 1, 8'h03, 8'h83, 1, 1);
    tbl[3]  = v(0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1);
    tbl[4]  = v(0, 1, 8'h0A, 0, 1, 8'h0A, 8'h8A, 1, 1);
    tbl[5]  = v(0, 1, 8'h0B, 0, 1, 8'h0A, 8'h8A, 2, 0);
    tbl[6]  = v(0, 1, 8'h0C, 0, 1, 8'h0A, 8'h8A, 2, 0);
    tbl[7]  = v(0, 1, 8'h0C, 1, 1, 8'h0B, 8'h8B, 1, 1);
    tbl[8]  = v(0, 1, 8'h0C, 1, 1, 8'h0C, 8'h8C, 1, 1);
    tbl[9]  = v(0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1);
    tbl[10] = v(0, 1, 8'h0D, 0, 1, 8'h0D, 8'h8D, 1, 1);
    tbl[11] = v(0, 1, 8'h0E, 0, 1, 8'h0D, 8'h8D, 2, 0);
    tbl[12] = v(1, 1, 8'h0F, 0, 0, 8'h00, 8'h00, 0, 1);
    tbl[13] = v(0, 1, 8'h11, 0, 1, 8'h11, 8'h91, 1, 1);
    tbl[14] = v(1, 1, 8'h12, 1, 0, 8'h00, 8'h00, 0, 1);
    tbl[15] = v(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1);
    tbl[16] = v(0, 1, 8'h13, 1, 1, 8'h13, 8'h93, 1, 1);
    #2;
    expect_st("reset", 0, 1, '0, '0, 0, 1);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      expect_st($sformatf("vec%0d", i), tbl[i].ov, tbl[i].ov, DW'(tbl[i].od), tbl[i].oc, tbl[i].occ, tbl[i].ir);
    end
    cyc(0, 1, 8'h21, 0);
    expect_st("fill2", 1, 1, DW'(8'h13), 8'h93, 2, 0);
    in_valid = 1;
    @(posedge clk);
    #2 rst = 1;
    #1 expect_st("async_rst", 0, 1, '0, '0, 0, 1);
    @(negedge clk);
    rst = 0;
    in_valid = 0;
    @(negedge clk);
    expect_st("post_rst", 0, 1, '0, '0, 0, 1);
    hold = 0;
    held = '0;
    for (int k = 0; k < 10000; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom % 3) != 0;
      in_data = {$urandom, $urandom};
      in_ctrl = 8'($urandom);
      #1;
      acc = in_valid & in_ready;
      take = out_valid & out_ready;
      if (take) begin
        head = q.size() != 0 ? q.pop_front() : 72'hx;
        chk("rnd_order", {out_ctrl, out_data}, head);
      end
      if (acc) q.push_back({in_ctrl, in_data});
      hold = out_valid & !out_ready;
      held = {out_ctrl, out_data};
      @(negedge clk);
      chk("rnd_occ", 128'(occupancy), 128'(q.size()));
      chk("rnd_valid", 128'(out_valid), 128'(q.size() != 0));
      chk("rnd_ready", 128'(in_ready), 128'(q.size() != 2));
      if (hold) chk("rnd_stable", {out_ctrl, out_data}, held);
    end
`ifdef PIPE_STAGE_PERF_EN
    in_valid = 0;
    out_ready = 0;
    flush = 0;
    rst = 1;
    #1 rst = 0;
    repeat (5) @(negedge clk);
    chk("bubble5", 128'(bubble_cnt), 5);
    chk("stall0", 128'(stall_cnt), 0);
    cyc(0, 1, 8'h55, 0);
    in_valid = 0;
    repeat (20) @(negedge clk);
    chk("stall_sat", 128'(stall_cnt), 15);
    chk("bubble6", 128'(bubble_cnt), 6);
    cyc(1, 0, 8'h00, 0);
    flush = 0;
    chk("stall_flush", 128'(stall_cnt), 15);
    chk("bubble_flush", 128'(bubble_cnt), 6);
    @(negedge clk);
    chk("bubble7", 128'(bubble_cnt), 7);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
